dmem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and access sequencer for the 64-bit byte-addressed data memory (8-byte little-endian words, combinational read, write on posedge clk when MemWrite=1).
- Port 0 is the CPU load/store path; port 1 is the loader/debug path, which preloads and inspects the sort array.
- Serialises accesses, checks alignment and range, and returns one response per accepted request.

---
 rtl/dmem_arbiter_if.sv | 35 +++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the two data-memory requesters of dmem_arbiter.
// The requester side uses the master modport and the arbiter uses the slave modport.
interface dmem_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_we;
  logic [63:0] req0_addr;
  logic [63:0] req0_wdata;
  logic        rsp0_valid;
  logic        rsp0_err;
  logic [63:0] rsp0_rdata;

  logic        req1_valid;
  logic        req1_ready;
  logic        req1_we;
  logic [63:0] req1_addr;
  logic [63:0] req1_wdata;
  logic        rsp1_valid;
  logic        rsp1_err;
  logic [63:0] rsp1_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and IDLE/ACCESS/RESP sequencer in front of the 64-bit data memory.
// One response per accepted request; misaligned or out-of-range requests skip ACCESS.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     bus,
  output logic [63:0]       Mem_Addr,
  output logic [63:0]       Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [63:0]       Read_Data,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [63:0] MAX_ADDR = 64'(DEPTH - 8);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              grant0, grant1, grant_any;
  logic              gnt_we, gnt_err;
  logic [63:0]       gnt_addr, gnt_wdata;

  always_comb begin : arbitrate
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        // contention goes to the port that did not win last time
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
    grant_any = grant0 | grant1;
    gnt_we    = grant1 ? bus.req1_we    : bus.req0_we;
    gnt_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    gnt_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
    gnt_err   = (gnt_addr[2:0] != 3'b000) || (gnt_addr > MAX_ADDR);
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = gnt_err ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : datapath_next
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (grant_any) begin
      last_grant_d = grant1;
      port_d       = grant1;
      we_d         = gnt_we;
      err_d        = gnt_err;
      rdata_d      = '0;
      // the memory bus only moves for requests that will actually access memory
      if (!gnt_err) begin
        mem_addr_d = gnt_addr;
        wdata_d    = gnt_wdata;
      end
    end
    if (grant0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (grant1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    if (state_q == ACCESS) rdata_d = we_q ? '0 : Read_Data;
  end

  always_ff @(posedge clk or negedge reset_n) begin : datapath_reg
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  always_comb begin : outputs
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    MemRead        = (state_q == ACCESS) && !we_q;
    MemWrite       = (state_q == ACCESS) &&  we_q;
    Mem_Addr       = mem_addr_q;
    Write_Data     = wdata_q;
    bus.rsp0_valid = (state_q == RESP) && !port_q;
    bus.rsp1_valid = (state_q == RESP) &&  port_q;
    bus.rsp0_err   = bus.rsp0_valid && err_q;
    bus.rsp1_err   = bus.rsp1_valid && err_q;
    bus.rsp0_rdata = bus.rsp0_valid ? rdata_q : '0;
    bus.rsp1_rdata = bus.rsp1_valid ? rdata_q : '0;
    grant_cnt0     = cnt0_q;
    grant_cnt1     = cnt1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory model, transaction-level reference checked every cycle,
// directed scenarios with literal expectations, then randomized two-port traffic.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset_n;
  logic [63:0]       Mem_Addr, Write_Data, Read_Data;
  logic              MemWrite, MemRead;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;
  logic              mem_init_n;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_Data  (Read_Data),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // data memory seen by the DUT
  logic [7:0] mem [256];
  always_ff @(posedge clk or negedge mem_init_n) begin
    if (!mem_init_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (MemWrite) begin
      for (int i = 0; i < 8; i++) mem[Mem_Addr[7:0] + 8'(i)] <= Write_Data[8*i +: 8];
    end
  end
  always_comb begin
    Read_Data = '0;
    for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = mem[Mem_Addr[7:0] + 8'(i)];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: transactions scheduled by cycle number
  logic [7:0]  ref_mem [256];
  int          c = 0, free_at = 0, acc_cyc = -1, rsp_cyc = -1;
  int          m_last = 1, m_cnt0 = 0, m_cnt1 = 0;
  int          t_port = 0;
  logic        t_we = 1'b0, t_err = 1'b0;
  logic [63:0] t_addr = '0, t_wdata = '0, t_rdata = '0, m_maddr = '0;
  int          mw_cnt = 0, mr_cnt = 0, rsp_cnt = 0;

  initial begin
    int          g;
    logic        v0, v1, exp_v0, exp_v1;
    logic [63:0] exp_rd;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      c++;
      if (!reset_n) begin
        chk("reset_outputs", 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp0_err,
                                  bus.rsp1_valid, bus.rsp1_err, MemRead, MemWrite,
                                  grant_cnt0 != '0, grant_cnt1 != '0, Mem_Addr != '0,
                                  Write_Data != '0, bus.rsp0_rdata != '0, bus.rsp1_rdata != '0}), '0);
        free_at = c + 1; acc_cyc = -1; rsp_cyc = -1;
        m_last = 1; m_cnt0 = 0; m_cnt1 = 0; m_maddr = '0;
      end else begin
        if (MemWrite) mw_cnt++;
        if (MemRead) mr_cnt++;
        if (bus.rsp0_valid || bus.rsp1_valid) rsp_cnt++;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        g = -1;
        if (c >= free_at) begin
          if (v0 && v1) g = 1 - m_last;
          else if (v0)  g = 0;
          else if (v1)  g = 1;
        end
        chk("ready0", 64'(bus.req0_ready), 64'(g == 0));
        chk("ready1", 64'(bus.req1_ready), 64'(g == 1));
        if (c == acc_cyc) begin
          m_maddr = t_addr;
          for (int i = 0; i < 8; i++) begin
            if (t_we) ref_mem[int'(t_addr) + i] = t_wdata[8*i +: 8];
            else t_rdata[8*i +: 8] = ref_mem[int'(t_addr) + i];
          end
        end
        chk("memread",  64'(MemRead),  64'((c == acc_cyc) && !t_we));
        chk("memwrite", 64'(MemWrite), 64'((c == acc_cyc) &&  t_we));
        chk("mem_addr", Mem_Addr, m_maddr);
        if ((c == acc_cyc) && t_we) chk("write_data", Write_Data, t_wdata);
        exp_v0 = (c == rsp_cyc) && (t_port == 0);
        exp_v1 = (c == rsp_cyc) && (t_port == 1);
        exp_rd = (t_err || t_we) ? 64'd0 : t_rdata;
        chk("rsp0_valid", 64'(bus.rsp0_valid), 64'(exp_v0));
        chk("rsp1_valid", 64'(bus.rsp1_valid), 64'(exp_v1));
        if (exp_v0) begin
          chk("rsp0_err", 64'(bus.rsp0_err), 64'(t_err));
          chk("rsp0_rdata", bus.rsp0_rdata, exp_rd);
        end
        if (exp_v1) begin
          chk("rsp1_err", 64'(bus.rsp1_err), 64'(t_err));
          chk("rsp1_rdata", bus.rsp1_rdata, exp_rd);
        end
        chk("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0));
        chk("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1));
        if (g >= 0) begin
          t_port  = g;
          t_we    = (g == 0) ? bus.req0_we    : bus.req1_we;
          t_addr  = (g == 0) ? bus.req0_addr  : bus.req1_addr;
          t_wdata = (g == 0) ? bus.req0_wdata : bus.req1_wdata;
          t_err   = ((t_addr % 64'd8) != 64'd0) || (t_addr > 64'(DEPTH - 8));
          acc_cyc = t_err ? -1 : c + 1;
          rsp_cyc = t_err ? c + 1 : c + 2;
          free_at = rsp_cyc + 1;
          m_last  = g;
          if (g == 0 && m_cnt0 < CMAX) m_cnt0++;
          if (g == 1 && m_cnt1 < CMAX) m_cnt1++;
        end
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [63:0] a, input logic [63:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  // returns at posedge+2 of the cycle after the handshake
  task automatic issue(input int p, input logic we, input logic [63:0] a, input logic [63:0] d);
    logic got;
    int   n;
    @(posedge clk); #2;
    set_req(p, 1'b1, we, a, d);
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      #2;
      got = (p == 0) ? bus.req0_ready : bus.req1_ready;
      @(posedge clk); #2;
      n++;
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
    chk("issue_accepted", 64'(got), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int          w0, r0, s0, n, code, diff;
    int          order[$];
    logic        act [2];
    logic        rwe [2];
    logic [63:0] radr [2];
    logic [63:0] rdat [2];
    int          kind;

    reset_n    = 1'b0;
    mem_init_n = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    #1 mem_init_n = 1'b0;
    #1 mem_init_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // loader preloads byte 0 = 172 and byte 32 = 15
    issue(1, 1'b1, 64'd0, 64'd172);
    issue(1, 1'b1, 64'd32, 64'd15);
    repeat (2) @(posedge clk);

    // port 0 load from 0: MemRead in T+1, response in T+2
    issue(0, 1'b0, 64'd0, 64'd0);
    #2;
    chk("t1_memread_t1", 64'(MemRead), 64'd1);
    chk("t1_no_rsp_t1", 64'(bus.rsp0_valid), 64'd0);
    @(posedge clk); #4;
    chk("t1_rsp_valid_t2", 64'(bus.rsp0_valid), 64'd1);
    chk("t1_rsp_err", 64'(bus.rsp0_err), 64'd0);
    chk("t1_rsp_rdata", bus.rsp0_rdata, 64'd172);

    // port 1 store then port 0 readback
    w0 = mw_cnt;
    issue(1, 1'b1, 64'd8, 64'h1122334455667788);
    repeat (3) @(posedge clk);
    chk("t2_one_write_pulse", 64'(mw_cnt - w0), 64'd1);
    issue(0, 1'b0, 64'd8, 64'd0);
    @(posedge clk); #4;
    chk("t2_readback", bus.rsp0_rdata, 64'h1122334455667788);
    repeat (2) @(posedge clk);

    // continuous contention from a fresh reset
    do_reset();
    @(posedge clk); #2;
    set_req(0, 1'b1, 1'b0, 64'd16, '0);
    set_req(1, 1'b1, 1'b0, 64'd24, '0);
    n = 0;
    while (order.size() < 4 && n < 40) begin
      #2;
      if (bus.req0_ready) order.push_back(0);
      if (bus.req1_ready) order.push_back(1);
      @(posedge clk); #2;
      n++;
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    code = 0;
    foreach (order[i]) code = code * 10 + order[i];
    chk("t3_grant_order", 64'(code), 64'd101);
    chk("t3_grant_count", 64'(order.size()), 64'd4);
    repeat (4) @(posedge clk);
    #2;
    chk("t3_cnt0", 64'(grant_cnt0), 64'd2);
    chk("t3_cnt1", 64'(grant_cnt1), 64'd2);

    // errored requests respond in T+1 without touching memory
    w0 = mw_cnt + mr_cnt;
    issue(0, 1'b0, 64'd3, '0);
    #2;
    chk("t4_mis_rsp_valid", 64'(bus.rsp0_valid), 64'd1);
    chk("t4_mis_rsp_err", 64'(bus.rsp0_err), 64'd1);
    chk("t4_mis_rsp_rdata", bus.rsp0_rdata, 64'd0);
    issue(1, 1'b1, 64'd252, 64'hDEADBEEFCAFEF00D);
    #2;
    chk("t4_oor_rsp_valid", 64'(bus.rsp1_valid), 64'd1);
    chk("t4_oor_rsp_err", 64'(bus.rsp1_err), 64'd1);
    chk("t4_oor_rsp_rdata", bus.rsp1_rdata, 64'd0);
    repeat (3) @(posedge clk);
    chk("t4_no_mem_pulse", 64'(mw_cnt + mr_cnt - w0), 64'd0);
    chk("t4_mem_tail", 64'({mem[255], mem[254], mem[253], mem[252]}), 64'd0);

    // reset during the ACCESS cycle of a store
    s0 = rsp_cnt;
    issue(1, 1'b1, 64'd32, 64'h00000000000000AA);
    chk("t5_memwrite_before", 64'(MemWrite), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_memwrite_drop", 64'(MemWrite), 64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("t5_byte32_kept", 64'(mem[32]), 64'd15);
    chk("t5_no_response", 64'(rsp_cnt - s0), 64'd0);
    chk("t5_cnt1_cleared", 64'(grant_cnt1), 64'd0);

    // saturation of the port 0 counter
    for (int k = 0; k < 20; k++) issue(0, 1'b0, 64'd0, '0);
    repeat (3) @(posedge clk);
    #2;
    chk("t6_cnt0_saturated", 64'(grant_cnt0), 64'(CMAX));

    // randomized traffic on both ports
    act[0] = 1'b0; act[1] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && ($urandom_range(0, 2) == 0)) begin
          act[p]  = 1'b1;
          rwe[p]  = 1'($urandom_range(0, 1));
          rdat[p] = {$urandom, $urandom};
          kind    = int'($urandom_range(0, 9));
          if (kind < 7)       radr[p] = 64'(8 * $urandom_range(0, 31));
          else if (kind == 7) radr[p] = 64'(8 * $urandom_range(0, 31) + $urandom_range(1, 7));
          else if (kind == 8) radr[p] = {32'h80000000 | $urandom, $urandom} & ~64'h7;
          else                radr[p] = 64'(DEPTH);
        end
        if (act[p]) set_req(p, 1'b1, rwe[p], radr[p], rdat[p]);
        else        set_req(p, 1'b0, 1'b0, '0, '0);
      end
      #2;
      if (act[0] && bus.req0_ready) act[0] = 1'b0;
      if (act[1] && bus.req1_ready) act[1] = 1'b0;
    end
    @(posedge clk); #2;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    #2;
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_image", 64'(diff), 64'd0);
    r0 = n_fail;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, r0);
    $finish;
  end

endmodule
